// File: rtl/bldc_run_sequencer.sv
// Run-state sequencer for the BLDC velocity loop: it paces the control chain, walks the motor
// through align, open-loop ramp and closed loop, slews the setpoint and latches faults.
module bldc_run_sequencer #(
    parameter int CONTROL_DIVIDER  = 1000,
    parameter int ALIGN_TICKS      = 500,
    parameter int RAMP_STEP        = 4,
    parameter int HANDOFF_VELOCITY = 200,
    parameter int ALIGN_GAIN       = 128,
    parameter int STALL_TICKS      = 2000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        clear_fault,
    input  logic        fault_in,
    input  logic [12:0] target_velocity,
    input  logic [12:0] filtered_velocity,
    output logic        control_tick,
    output logic [12:0] velocity_setpoint,
    output logic        commutation_enable,
    output logic        gain_select,
    output logic [9:0]  open_loop_gain,
    output logic [2:0]  state,
    output logic        fault_latched
);

    // No handshakes here: start, stop, clear_fault and fault_in are levels sampled every
    // cycle with priority fault_in > stop > start; outputs follow one clock later.

    localparam int DW        = (CONTROL_DIVIDER > 2) ? $clog2(CONTROL_DIVIDER) : 1;
    localparam int PHASE_MAX = (ALIGN_TICKS > STALL_TICKS) ? ALIGN_TICKS : STALL_TICKS;
    localparam int PW        = $clog2(PHASE_MAX + 1);

    localparam logic [DW-1:0] DIV_LAST     = DW'(CONTROL_DIVIDER - 1);
    localparam logic [DW-1:0] DIV_PRE_LAST = DW'(CONTROL_DIVIDER - 2);
    localparam logic [PW-1:0] ALIGN_END    = PW'(ALIGN_TICKS);
    localparam logic [PW-1:0] STALL_END    = PW'(STALL_TICKS);
    localparam logic [13:0]   STEP14       = 14'(RAMP_STEP);
    localparam logic [13:0]   SP_MAX       = 14'd8191;
    localparam logic [12:0]   HANDOFF13    = 13'(HANDOFF_VELOCITY);
    localparam logic [9:0]    GAIN10       = 10'(ALIGN_GAIN);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ALIGN    = 3'd1,
        S_RAMP     = 3'd2,
        S_CLOSED   = 3'd3,
        S_STOPPING = 3'd4,
        S_FAULT    = 3'd5
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [DW-1:0] div_cnt;
    logic [PW-1:0] phase_q;
    logic [PW-1:0] phase_inc;
    logic [12:0]   setpoint_q;
    logic [12:0]   setpoint_d;
    logic          enable_d;
    logic          gsel_d;
    logic [9:0]    gain_d;
    logic          fault_d;

    logic [13:0]   sp_ext;
    logic [13:0]   tgt_ext;
    logic [13:0]   sp_up_raw;
    logic [13:0]   sp_up;
    logic [13:0]   sp_dn;
    logic [12:0]   ramp_sp;
    logic [12:0]   closed_sp;
    logic          align_done;
    logic          stall_done;
    logic          at_handoff;

    assign state             = state_q;
    assign velocity_setpoint = setpoint_q;

    // Free-running divider; control_tick is registered so it is high while the count sits at its last value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt      <= '0;
            control_tick <= 1'b0;
        end else begin
            div_cnt      <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
            control_tick <= (div_cnt == DIV_PRE_LAST);
        end
    end

    // Phase timer counts ticks in the current state and saturates instead of wrapping.
    assign phase_inc  = (phase_q == {PW{1'b1}}) ? phase_q : phase_q + PW'(1);
    assign align_done = (phase_inc >= ALIGN_END);
    assign stall_done = (phase_inc >= STALL_END);
    assign at_handoff = (filtered_velocity >= HANDOFF13);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q <= '0;
        end else if (state_d != state_q) begin
            phase_q <= '0;
        end else if (control_tick) begin
            phase_q <= phase_inc;
        end
    end

    // Setpoint arithmetic is widened to 14 bits and clamped so it never wraps.
    always_comb begin
        sp_ext    = {1'b0, setpoint_q};
        tgt_ext   = {1'b0, target_velocity};
        sp_up_raw = sp_ext + STEP14;
        sp_up     = (sp_up_raw > SP_MAX) ? SP_MAX : sp_up_raw;
        sp_dn     = (sp_ext > STEP14) ? (sp_ext - STEP14) : 14'd0;
        ramp_sp   = (sp_up > tgt_ext) ? target_velocity : sp_up[12:0];
        if (sp_ext < tgt_ext) begin
            closed_sp = ((tgt_ext - sp_ext) < STEP14) ? target_velocity : sp_up[12:0];
        end else if (sp_ext > tgt_ext) begin
            closed_sp = ((sp_ext - tgt_ext) < STEP14) ? target_velocity : sp_dn[12:0];
        end else begin
            closed_sp = target_velocity;
        end
    end

    always_comb begin
        state_d    = state_q;
        setpoint_d = setpoint_q;
        case (state_q)
            S_IDLE: begin
                if (fault_in) begin
                    state_d = S_FAULT;
                end else if (start && !stop) begin
                    state_d = S_ALIGN;
                end
            end
            S_ALIGN: begin
                if (fault_in) begin
                    state_d = S_FAULT;
                end else if (stop) begin
                    state_d = S_IDLE;
                end else if (control_tick && align_done) begin
                    state_d = S_RAMP;
                end
            end
            S_RAMP: begin
                if (fault_in) begin
                    state_d = S_FAULT;
                end else if (stop) begin
                    state_d = S_IDLE;
                end else if (control_tick) begin
                    setpoint_d = ramp_sp;
                    if (at_handoff) begin
                        state_d = S_CLOSED;
                    end else if (stall_done) begin
                        state_d = S_FAULT;
                    end
                end
            end
            S_CLOSED: begin
                if (fault_in) begin
                    state_d = S_FAULT;
                end else if (stop) begin
                    state_d = S_STOPPING;
                end else if (control_tick) begin
                    setpoint_d = closed_sp;
                end
            end
            S_STOPPING: begin
                if (fault_in) begin
                    state_d = S_FAULT;
                end else if ((setpoint_q == 13'd0) && !at_handoff) begin
                    state_d = S_IDLE;
                end else if (control_tick) begin
                    setpoint_d = sp_dn[12:0];
                end
            end
            S_FAULT: begin
                if (clear_fault && !fault_in) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Idle, align and fault always present a zero setpoint to the PI stage.
        if ((state_d == S_IDLE) || (state_d == S_ALIGN) || (state_d == S_FAULT)) begin
            setpoint_d = 13'd0;
        end
    end

    // Output decode from the next state so the registered outputs line up with the state register.
    always_comb begin
        enable_d = 1'b0;
        gsel_d   = 1'b0;
        gain_d   = 10'd0;
        fault_d  = 1'b0;
        case (state_d)
            S_ALIGN, S_RAMP: begin
                enable_d = 1'b1;
                gain_d   = GAIN10;
            end
            S_CLOSED, S_STOPPING: begin
                enable_d = 1'b1;
                gsel_d   = 1'b1;
            end
            S_FAULT: begin
                fault_d = 1'b1;
            end
            default: begin
                enable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q            <= S_IDLE;
            setpoint_q         <= 13'd0;
            commutation_enable <= 1'b0;
            gain_select        <= 1'b0;
            open_loop_gain     <= 10'd0;
            fault_latched      <= 1'b0;
        end else begin
            state_q            <= state_d;
            setpoint_q         <= setpoint_d;
            commutation_enable <= enable_d;
            gain_select        <= gsel_d;
            open_loop_gain     <= gain_d;
            fault_latched      <= fault_d;
        end
    end

endmodule

// File: tb/tb_bldc_run_sequencer.sv
// Self-checking bench for bldc_run_sequencer: tick cadence, start-up, handoff, stop,
// stall, fault priority and asynchronous reset, with a setpoint scoreboard.
module tb_bldc_run_sequencer;

    localparam int D       = 4;
    localparam int ALIGN   = 3;
    localparam int STEP    = 10;
    localparam int HANDOFF = 50;
    localparam int GAIN    = 128;
    localparam int STALL   = 20;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ALIGN    = 3'd1;
    localparam logic [2:0] ST_RAMP     = 3'd2;
    localparam logic [2:0] ST_CLOSED   = 3'd3;
    localparam logic [2:0] ST_STOPPING = 3'd4;
    localparam logic [2:0] ST_FAULT    = 3'd5;

    logic        clk;
    logic        reset;
    logic        start;
    logic        stop;
    logic        clear_fault;
    logic        fault_in;
    logic [12:0] target_velocity;
    logic [12:0] filtered_velocity;
    logic        control_tick;
    logic [12:0] velocity_setpoint;
    logic        commutation_enable;
    logic        gain_select;
    logic [9:0]  open_loop_gain;
    logic [2:0]  state;
    logic        fault_latched;

    int checks;
    int errors;
    logic [12:0] exp_q[$];

    bldc_run_sequencer #(
        .CONTROL_DIVIDER (D),
        .ALIGN_TICKS     (ALIGN),
        .RAMP_STEP       (STEP),
        .HANDOFF_VELOCITY(HANDOFF),
        .ALIGN_GAIN      (GAIN),
        .STALL_TICKS     (STALL)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .stop              (stop),
        .clear_fault       (clear_fault),
        .fault_in          (fault_in),
        .target_velocity   (target_velocity),
        .filtered_velocity (filtered_velocity),
        .control_tick      (control_tick),
        .velocity_setpoint (velocity_setpoint),
        .commutation_enable(commutation_enable),
        .gain_select       (gain_select),
        .open_loop_gain    (open_loop_gain),
        .state             (state),
        .fault_latched     (fault_latched)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Waits for the next tick cycle, then for the negedge after the edge that acts on it.
    task automatic wait_tick();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 3 * D && !seen; n++) begin
            @(negedge clk);
            if (control_tick) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout: got no control_tick within %0d cycles, required one", 3 * D);
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({state, velocity_setpoint, commutation_enable, gain_select, open_loop_gain, fault_latched, control_tick} !== '0) begin
            errors++;
            $display("FAIL reset_values: got state=%0d sp=%0d en=%b gs=%b gain=%0d fl=%b tick=%b, required all zero",
                     state, velocity_setpoint, commutation_enable, gain_select, open_loop_gain, fault_latched, control_tick);
        end
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            checks++;
            if (control_tick !== (((k + 1) % D) == 0)) begin
                errors++;
                $display("FAIL tick_cadence: cycle %0d got %b required %b", k + 1, control_tick, ((k + 1) % D) == 0);
            end
        end
        checks++;
        if ({state, velocity_setpoint, commutation_enable, gain_select, open_loop_gain, fault_latched} !== '0) begin
            errors++;
            $display("FAIL idle_hold: got state=%0d sp=%0d en=%b, required reset values", state, velocity_setpoint, commutation_enable);
        end
    endtask

    task automatic test_full_start();
        logic [12:0] exp_sp;
        target_velocity   = 13'd100;
        filtered_velocity = 13'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (state !== ST_ALIGN || commutation_enable !== 1'b1 || open_loop_gain !== 10'(GAIN) || gain_select !== 1'b0 || velocity_setpoint !== 13'd0) begin
            errors++;
            $display("FAIL align_entry: got state=%0d en=%b gain=%0d gs=%b sp=%0d, required 1 1 %0d 0 0",
                     state, commutation_enable, open_loop_gain, gain_select, velocity_setpoint, GAIN);
        end
        for (int t = 1; t <= ALIGN; t++) begin
            wait_tick();
            checks++;
            if (state !== ((t == ALIGN) ? ST_RAMP : ST_ALIGN)) begin
                errors++;
                $display("FAIL align_len: tick %0d got state %0d required %0d", t, state, (t == ALIGN) ? ST_RAMP : ST_ALIGN);
            end
        end
        for (int v = 10; v <= 30; v += STEP) exp_q.push_back(13'(v));
        while (exp_q.size() > 0) begin
            wait_tick();
            exp_sp = exp_q.pop_front();
            checks++;
            if (velocity_setpoint !== exp_sp || state !== ST_RAMP) begin
                errors++;
                $display("FAIL ramp_sp: got sp=%0d state=%0d required sp=%0d state=2", velocity_setpoint, state, exp_sp);
            end
        end
        filtered_velocity = 13'd55;
        exp_q.push_back(13'd40);
        for (int v = 50; v <= 100; v += STEP) exp_q.push_back(13'(v));
        exp_q.push_back(13'd100);
        exp_q.push_back(13'd100);
        while (exp_q.size() > 0) begin
            wait_tick();
            exp_sp = exp_q.pop_front();
            checks++;
            if (velocity_setpoint !== exp_sp || state !== ST_CLOSED || gain_select !== 1'b1 || open_loop_gain !== 10'd0) begin
                errors++;
                $display("FAIL closed_sp: got sp=%0d state=%0d gs=%b gain=%0d required sp=%0d state=3 gs=1 gain=0",
                         velocity_setpoint, state, gain_select, open_loop_gain, exp_sp);
            end
        end
    endtask

    task automatic test_stop();
        logic [12:0] exp_sp;
        target_velocity = 13'd25;
        for (int v = 90; v >= 30; v -= STEP) exp_q.push_back(13'(v));
        exp_q.push_back(13'd25);
        exp_q.push_back(13'd25);
        while (exp_q.size() > 0) begin
            wait_tick();
            exp_sp = exp_q.pop_front();
            checks++;
            if (velocity_setpoint !== exp_sp || state !== ST_CLOSED) begin
                errors++;
                $display("FAIL slew_down: got sp=%0d state=%0d required sp=%0d state=3", velocity_setpoint, state, exp_sp);
            end
        end
        filtered_velocity = 13'd60;
        stop = 1'b1;
        @(negedge clk);
        checks++;
        if (state !== ST_STOPPING || velocity_setpoint !== 13'd25 || commutation_enable !== 1'b1 || gain_select !== 1'b1) begin
            errors++;
            $display("FAIL stop_entry: got state=%0d sp=%0d en=%b gs=%b required 4 25 1 1",
                     state, velocity_setpoint, commutation_enable, gain_select);
        end
        exp_q.push_back(13'd15);
        exp_q.push_back(13'd5);
        exp_q.push_back(13'd0);
        while (exp_q.size() > 0) begin
            wait_tick();
            exp_sp = exp_q.pop_front();
            checks++;
            if (velocity_setpoint !== exp_sp || state !== ST_STOPPING) begin
                errors++;
                $display("FAIL stop_ramp: got sp=%0d state=%0d required sp=%0d state=4", velocity_setpoint, state, exp_sp);
            end
        end
        start = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (state !== ST_STOPPING) begin
            errors++;
            $display("FAIL stop_hold: got state %0d required 4", state);
        end
        start = 1'b0;
        filtered_velocity = 13'd40;
        @(negedge clk);
        checks++;
        if (state !== ST_IDLE || commutation_enable !== 1'b0 || gain_select !== 1'b0) begin
            errors++;
            $display("FAIL stop_exit: got state=%0d en=%b gs=%b required 0 0 0", state, commutation_enable, gain_select);
        end
        stop = 1'b0;
    endtask

    task automatic test_stall();
        logic [12:0] exp_sp;
        target_velocity   = 13'd100;
        filtered_velocity = 13'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (ALIGN) wait_tick();
        for (int t = 1; t < STALL; t++) exp_q.push_back(13'((t * STEP > 100) ? 100 : t * STEP));
        while (exp_q.size() > 0) begin
            wait_tick();
            exp_sp = exp_q.pop_front();
            checks++;
            if (velocity_setpoint !== exp_sp || state !== ST_RAMP) begin
                errors++;
                $display("FAIL stall_ramp: got sp=%0d state=%0d required sp=%0d state=2", velocity_setpoint, state, exp_sp);
            end
        end
        wait_tick();
        checks++;
        if (state !== ST_FAULT || commutation_enable !== 1'b0 || fault_latched !== 1'b1 || velocity_setpoint !== 13'd0) begin
            errors++;
            $display("FAIL stall_fault: got state=%0d en=%b fl=%b sp=%0d required 5 0 1 0",
                     state, commutation_enable, fault_latched, velocity_setpoint);
        end
        start = 1'b1;
        repeat ($urandom_range(3, 8)) @(negedge clk);
        checks++;
        if (state !== ST_FAULT) begin
            errors++;
            $display("FAIL fault_ignores_start: got state %0d required 5", state);
        end
        start = 1'b0;
        clear_fault = 1'b1;
        @(negedge clk);
        clear_fault = 1'b0;
        checks++;
        if (state !== ST_IDLE || fault_latched !== 1'b0) begin
            errors++;
            $display("FAIL clear_fault: got state=%0d fl=%b required 0 0", state, fault_latched);
        end
    endtask

    task automatic test_fault_priority();
        target_velocity   = 13'd100;
        filtered_velocity = 13'd55;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (ALIGN + 1) wait_tick();
        checks++;
        if (state !== ST_CLOSED || velocity_setpoint !== 13'd10) begin
            errors++;
            $display("FAIL prio_setup: got state=%0d sp=%0d required 3 10", state, velocity_setpoint);
        end
        fault_in = 1'b1;
        stop     = 1'b1;
        @(negedge clk);
        checks++;
        if (state !== ST_FAULT || commutation_enable !== 1'b0 || fault_latched !== 1'b1) begin
            errors++;
            $display("FAIL fault_over_stop: got state=%0d en=%b fl=%b required 5 0 1", state, commutation_enable, fault_latched);
        end
        start       = 1'b1;
        clear_fault = 1'b1;
        repeat (2 * D) @(negedge clk);
        checks++;
        if (state !== ST_FAULT) begin
            errors++;
            $display("FAIL clear_blocked: got state %0d required 5", state);
        end
        fault_in = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        @(negedge clk);
        clear_fault = 1'b0;
        checks++;
        if (state !== ST_IDLE) begin
            errors++;
            $display("FAIL clear_release: got state %0d required 0", state);
        end
        fault_in = 1'b1;
        @(negedge clk);
        fault_in = 1'b0;
        checks++;
        if (state !== ST_FAULT || fault_latched !== 1'b1) begin
            errors++;
            $display("FAIL idle_fault: got state=%0d fl=%b required 5 1", state, fault_latched);
        end
        clear_fault = 1'b1;
        @(negedge clk);
        clear_fault = 1'b0;
    endtask

    task automatic test_reset_mid_ramp();
        target_velocity   = 13'd100;
        filtered_velocity = 13'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (ALIGN + 2) wait_tick();
        checks++;
        if (state !== ST_RAMP || velocity_setpoint !== 13'd20) begin
            errors++;
            $display("FAIL mid_ramp_setup: got state=%0d sp=%0d required 2 20", state, velocity_setpoint);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({state, velocity_setpoint, commutation_enable, gain_select, open_loop_gain, fault_latched, control_tick} !== '0) begin
            errors++;
            $display("FAIL async_reset: got state=%0d sp=%0d en=%b gs=%b gain=%0d fl=%b tick=%b, required all zero",
                     state, velocity_setpoint, commutation_enable, gain_select, open_loop_gain, fault_latched, control_tick);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3 * D) @(negedge clk);
        checks++;
        if (state !== ST_IDLE || velocity_setpoint !== 13'd0 || commutation_enable !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: got state=%0d sp=%0d en=%b required 0 0 0", state, velocity_setpoint, commutation_enable);
        end
    endtask

    initial begin
        checks            = 0;
        errors            = 0;
        reset             = 1'b1;
        start             = 1'b0;
        stop              = 1'b0;
        clear_fault       = 1'b0;
        fault_in          = 1'b0;
        target_velocity   = 13'd0;
        filtered_velocity = 13'd0;
        test_reset();
        test_full_start();
        test_stop();
        test_stall();
        test_fault_priority();
        test_reset_mid_ramp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
